// File: rtl/if_sequencer.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake and holds the fetched word for decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets fault to ERR instead of being truncated.
module if_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, ERR} state_e;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        squash_q, squash_d;
  logic [31:0] redir_pc;
  logic [31:0] tgt;

  // Without the check the low bits are dropped so the target is always word aligned.
  assign redir_pc = ALIGN_CHECK ? redirect_pc : {redirect_pc[31:2], 2'b00};

  function automatic logic misaligned(input logic [31:0] a);
    return ALIGN_CHECK && (a[1:0] != 2'b00);
  endfunction

  function automatic state_e range_state(input logic [31:0] a);
    return ((PC_LIMIT != 32'd0) && (a >= PC_LIMIT)) ? ERR : FETCH;
  endfunction

  function automatic state_e redir_state(input logic [31:0] a);
    return misaligned(a) ? ERR : range_state(a);
  endfunction

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_pc_d   = inst_pc_q;
    inst_data_d = inst_data_q;
    pend_pc_d   = pend_pc_q;
    squash_d    = squash_q;
    tgt         = pend_pc_q;
    case (state_q)
      IDLE: state_d = range_state(pc_q);
      FETCH: begin
        if (imem_ack) begin
          if (squash_q || redirect_valid) begin
            // A redirect arriving together with the ack overrides any older pending one.
            tgt      = redirect_valid ? redir_pc : pend_pc_q;
            pc_d     = tgt;
            squash_d = 1'b0;
            state_d  = redir_state(tgt);
          end else begin
            inst_data_d = imem_rdata;
            inst_pc_d   = pc_q;
            pc_d        = pc_q + 32'd4;
            state_d     = VALID;
          end
        end else if (redirect_valid) begin
          pend_pc_d = redir_pc;
          squash_d  = 1'b1;
        end
      end
      VALID: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = redir_state(redir_pc);
        end else if (inst_ready && !stall) begin
          state_d = range_state(pc_q);
        end
      end
      ERR: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = redir_state(redir_pc);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      inst_pc_q   <= 32'd0;
      inst_data_q <= 32'd0;
      pend_pc_q   <= 32'd0;
      squash_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_pc_q   <= inst_pc_d;
      inst_data_q <= inst_data_d;
      pend_pc_q   <= pend_pc_d;
      squash_q    <= squash_d;
    end
  end

  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == VALID);
  assign fetch_err  = (state_q == ERR);
  assign inst_pc    = inst_pc_q;
  assign inst_data  = inst_data_q;

endmodule
